// File: rtl/smm_pkg.sv
// Shared types and sizes for the sparse matrix multiplier input path.
package smm_pkg;

    localparam logic SIZE16 = 1'b0;
    localparam logic SIZE32 = 1'b1;

    localparam int unsigned IDX_W      = 5;
    localparam int unsigned VAL_W      = 4;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned LIST_DEPTH = 1024;
    localparam int unsigned DIM_MAX    = 32;
    localparam int unsigned ROW_W      = DIM_MAX * VAL_W;
    localparam int unsigned PTR_W      = $clog2(LIST_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_SIZE,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic [VAL_W-1:0] val;
    } triple_t;

    // Highest row/column index for the selected matrix size.
    function automatic logic [IDX_W-1:0] last_idx(input logic size);
        return (size == SIZE32) ? IDX_W'(31) : IDX_W'(15);
    endfunction

endpackage

// File: rtl/smm_coo_tx_if.sv
// Dense input rows in, size pulse and COO triple streams out.
interface smm_coo_tx_if;
    import smm_pkg::*;

    logic             in_valid;
    logic             in_size;
    logic [ROW_W-1:0] in_row_a;
    logic [ROW_W-1:0] in_row_b;
    logic             busy;
    logic             out_valid_size;
    logic             out_size;
    logic             out_valid_a;
    logic [IDX_W-1:0] out_row_a;
    logic [IDX_W-1:0] out_col_a;
    logic [VAL_W-1:0] out_val_a;
    logic             out_valid_b;
    logic [IDX_W-1:0] out_row_b;
    logic [IDX_W-1:0] out_col_b;
    logic [VAL_W-1:0] out_val_b;
    logic             done;

    modport master (
        output in_valid, in_size, in_row_a, in_row_b,
        input  busy, out_valid_size, out_size,
        input  out_valid_a, out_row_a, out_col_a, out_val_a,
        input  out_valid_b, out_row_b, out_col_b, out_val_b,
        input  done
    );

    modport slave (
        input  in_valid, in_size, in_row_a, in_row_b,
        output busy, out_valid_size, out_size,
        output out_valid_a, out_row_a, out_col_a, out_val_a,
        output out_valid_b, out_row_b, out_col_b, out_val_b,
        output done
    );

endinterface

// File: rtl/smm_coo_list.sv
// One matrix: dense row buffer, scan-time compaction into a triple list, emit pointer.
module smm_coo_list
    import smm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             scan_en,
    input  logic [IDX_W-1:0] scan_r,
    input  logic [IDX_W-1:0] scan_c,
    input  logic             emit_en,
    output logic             exhausted_c,
    output logic             out_valid,
    output triple_t          out_trip
);

    logic [DIM_MAX-1:0][VAL_W-1:0] dense [DIM_MAX];
    triple_t                       list_mem [LIST_DEPTH];
    logic [CNT_W-1:0]              count;
    logic [CNT_W-1:0]              rd_ptr;
    logic [VAL_W-1:0]              scan_val_c;
    logic                          hit_c;

    assign scan_val_c  = dense[scan_r][scan_c];
    assign hit_c       = scan_en && (scan_val_c != '0);
    assign exhausted_c = (rd_ptr == count);

    // Dense buffer: row writes during load, wiped at job end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DIM_MAX); i++) dense[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(DIM_MAX); i++) dense[i] <= '0;
        end else if (wr_en) begin
            dense[wr_row] <= wr_data;
        end
    end

    // Triple storage; contents beyond count are never read.
    always_ff @(posedge clk) begin
        if (hit_c) list_mem[count[PTR_W-1:0]] <= '{row: scan_r, col: scan_c, val: scan_val_c};
    end

    // Count, emit pointer and the registered triple output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_trip  <= '0;
        end else if (clr) begin
            count     <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_trip  <= '0;
        end else begin
            if (hit_c) count <= count + CNT_W'(1);
            if (emit_en && !exhausted_c) begin
                out_valid <= 1'b1;
                out_trip  <= list_mem[rd_ptr[PTR_W-1:0]];
                rd_ptr    <= rd_ptr + CNT_W'(1);
            end else begin
                out_valid <= 1'b0;
                out_trip  <= '0;
            end
        end
    end

endmodule

// File: rtl/smm_coo_tx.sv
// Dense-to-sparse transmitter: load rows, scan to COO lists, emit size pulse and triples.
module smm_coo_tx
    import smm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    smm_coo_tx_if.slave  bus
);

    state_t           state;
    state_t           state_next;
    logic             size_q;
    logic [IDX_W-1:0] row_cnt;
    logic [IDX_W-1:0] scan_r;
    logic [IDX_W-1:0] scan_c;
    logic [IDX_W-1:0] last_c;
    logic             accept_c;
    logic             scan_end_c;
    logic [IDX_W-1:0] wr_row_c;
    logic             exh_a_c;
    logic             exh_b_c;
    logic             busy_q;
    logic             valid_size_q;
    logic             out_size_q;
    logic             done_q;
    logic             a_valid;
    logic             b_valid;
    triple_t          a_trip;
    triple_t          b_trip;

    assign last_c     = last_idx(size_q);
    assign accept_c   = bus.in_valid && ((state == ST_IDLE) || (state == ST_LOAD));
    assign scan_end_c = (state == ST_SCAN) && (scan_r == last_c) && (scan_c == last_c);
    assign wr_row_c   = (state == ST_IDLE) ? '0 : row_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_next = ST_LOAD;
            ST_LOAD: if (bus.in_valid && (row_cnt == last_c)) state_next = ST_SCAN;
            ST_SCAN: if (scan_end_c) state_next = ST_SIZE;
            ST_SIZE: state_next = ST_EMIT;
            ST_EMIT: if (exh_a_c && exh_b_c) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Size latch and load row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= SIZE16;
            row_cnt <= '0;
        end else if ((state == ST_IDLE) && bus.in_valid) begin
            size_q  <= bus.in_size;
            row_cnt <= IDX_W'(1);
        end else if ((state == ST_LOAD) && bus.in_valid) begin
            row_cnt <= row_cnt + IDX_W'(1);
        end else if (state == ST_DONE) begin
            row_cnt <= '0;
        end
    end

    // Row-major scan position, held at origin outside SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_r <= '0;
            scan_c <= '0;
        end else if (state != ST_SCAN) begin
            scan_r <= '0;
            scan_c <= '0;
        end else if (scan_c == last_c) begin
            scan_c <= '0;
            scan_r <= scan_r + IDX_W'(1);
        end else begin
            scan_c <= scan_c + IDX_W'(1);
        end
    end

    // Status outputs registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            valid_size_q <= 1'b0;
            out_size_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            busy_q       <= (state_next != ST_IDLE);
            valid_size_q <= (state_next == ST_SIZE);
            out_size_q   <= (state_next == ST_SIZE) && size_q;
            done_q       <= (state_next == ST_DONE);
        end
    end

    smm_coo_list u_list_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (state == ST_DONE),
        .wr_en       (accept_c),
        .wr_row      (wr_row_c),
        .wr_data     (bus.in_row_a),
        .scan_en     (state == ST_SCAN),
        .scan_r      (scan_r),
        .scan_c      (scan_c),
        .emit_en     (state_next == ST_EMIT),
        .exhausted_c (exh_a_c),
        .out_valid   (a_valid),
        .out_trip    (a_trip)
    );

    smm_coo_list u_list_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (state == ST_DONE),
        .wr_en       (accept_c),
        .wr_row      (wr_row_c),
        .wr_data     (bus.in_row_b),
        .scan_en     (state == ST_SCAN),
        .scan_r      (scan_r),
        .scan_c      (scan_c),
        .emit_en     (state_next == ST_EMIT),
        .exhausted_c (exh_b_c),
        .out_valid   (b_valid),
        .out_trip    (b_trip)
    );

    assign bus.busy           = busy_q;
    assign bus.out_valid_size = valid_size_q;
    assign bus.out_size       = out_size_q;
    assign bus.done           = done_q;
    assign bus.out_valid_a    = a_valid;
    assign bus.out_row_a      = a_trip.row;
    assign bus.out_col_a      = a_trip.col;
    assign bus.out_val_a      = a_trip.val;
    assign bus.out_valid_b    = b_valid;
    assign bus.out_row_b      = b_trip.row;
    assign bus.out_col_b      = b_trip.col;
    assign bus.out_val_b      = b_trip.val;

endmodule

// File: tb/tb_smm_coo_tx.sv
// Scoreboard bench for smm_coo_tx with a matrix-level reference model.
module tb_smm_coo_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned last_cyc;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  row;
        logic [4:0]  col;
        logic [3:0]  val;
    } ev_t;

    ev_t        q_sz[$];
    ev_t        q_a[$];
    ev_t        q_b[$];
    ev_t        q_done[$];
    logic [3:0] mat_a [32][32];
    logic [3:0] mat_b [32][32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    smm_coo_tx_if bus();

    smm_coo_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input int unsigned c, input int r, input int k, input int v);
        ev_t e;
        e.cyc = 32'(c);
        e.row = 5'(r);
        e.col = 5'(k);
        e.val = 4'(v);
        return e;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.busy, bus.out_valid_size, bus.out_size,
                    bus.out_valid_a, bus.out_row_a, bus.out_col_a, bus.out_val_a,
                    bus.out_valid_b, bus.out_row_b, bus.out_col_b, bus.out_val_b,
                    bus.done});
    endfunction

    // Pop the expected event of one stream and compare; idle outputs must be zero.
    task automatic mon(input int which, input string name, input logic v, input ev_t got);
        ev_t e;
        bit  have;
        if (!v) begin
            if (which != 3) chk({name, "_idle"}, 64'({got.row, got.col, got.val}), 64'(0));
        end else begin
            have = 1'b0;
            case (which)
                0: if (q_sz.size() != 0)   begin e = q_sz.pop_front();   have = 1'b1; end
                1: if (q_a.size() != 0)    begin e = q_a.pop_front();    have = 1'b1; end
                2: if (q_b.size() != 0)    begin e = q_b.pop_front();    have = 1'b1; end
                default: if (q_done.size() != 0) begin e = q_done.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s unexpected: got %0h (cycle %0d)", name, got, cyc);
            end else begin
                chk(name, 64'(got), 64'(e));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, "size", bus.out_valid_size, mk_ev(cyc, 0, 0, int'(bus.out_size)));
            mon(1, "a_triple", bus.out_valid_a,
                mk_ev(cyc, int'(bus.out_row_a), int'(bus.out_col_a), int'(bus.out_val_a)));
            mon(2, "b_triple", bus.out_valid_b,
                mk_ev(cyc, int'(bus.out_row_b), int'(bus.out_col_b), int'(bus.out_val_b)));
            mon(3, "done", bus.done, mk_ev(cyc, 0, 0, 0));
        end
    end

    function automatic logic [127:0] pack_row(input bit is_a, input int r, input int n);
        logic [127:0] row;
        logic [3:0]   v;
        row = '0;
        for (int c = 0; c < 32; c++) begin
            if (c < n) v = is_a ? mat_a[r][c] : mat_b[r][c];
            else       v = 4'($urandom);
            row[4*c +: 4] = v;
        end
        return row;
    endfunction

    task automatic clear_mats();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                mat_a[r][c] = 4'd0;
                mat_b[r][c] = 4'd0;
            end
    endtask

    task automatic fill_rand(input int pct);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                mat_a[r][c] = ($urandom_range(99) < 32'(pct)) ? 4'($urandom_range(15, 1)) : 4'd0;
                mat_b[r][c] = ($urandom_range(99) < 32'(pct)) ? 4'($urandom_range(15, 1)) : 4'd0;
            end
    endtask

    // Drive all rows, then push the expected size pulse, triple lists and done.
    task automatic load_job(input bit sz, input int gap, input bit junk);
        int          n;
        int          ka;
        int          kb;
        int unsigned base;
        n = sz ? 32 : 16;
        chk("busy_idle", 64'(bus.busy), 64'(0));
        for (int r = 0; r < n; r++) begin
            bus.in_valid = 1'b1;
            bus.in_size  = (r == 0) ? sz : 1'($urandom);
            bus.in_row_a = pack_row(1'b1, r, n);
            bus.in_row_b = pack_row(1'b0, r, n);
            if (r == n - 1) last_cyc = cyc;
            @(posedge clk); #1;
            if (r == 0) chk("busy_rise", 64'(bus.busy), 64'(1));
            if (r != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    bus.in_row_a = {4{$urandom}};
                    bus.in_row_b = {4{$urandom}};
                    @(posedge clk); #1;
                end
            end
        end
        bus.in_valid = 1'b0;
        if (junk) begin
            for (int j = 0; j < 4; j++) begin
                bus.in_valid = 1'b1;
                bus.in_size  = 1'($urandom);
                bus.in_row_a = {4{$urandom | 32'h1111_1111}};
                bus.in_row_b = {4{$urandom | 32'h1111_1111}};
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
        end
        base = last_cyc + 32'(n * n);
        q_sz.push_back(mk_ev(base + 1, 0, 0, int'(sz)));
        ka = 0;
        kb = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (mat_a[r][c] != 0) begin
                    q_a.push_back(mk_ev(base + 2 + 32'(ka), r, c, int'(mat_a[r][c])));
                    ka++;
                end
                if (mat_b[r][c] != 0) begin
                    q_b.push_back(mk_ev(base + 2 + 32'(kb), r, c, int'(mat_b[r][c])));
                    kb++;
                end
            end
        if (ka == 0 && kb == 0) q_done.push_back(mk_ev(base + 3, 0, 0, 0));
        else q_done.push_back(mk_ev(base + 2 + 32'((ka > kb) ? ka : kb), 0, 0, 0));
    endtask

    task automatic wait_job();
        int budget;
        budget = 2200;
        while (q_done.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("done_pending", 64'(q_done.size()), 64'(0));
        chk("a_pending", 64'(q_a.size()), 64'(0));
        chk("b_pending", 64'(q_b.size()), 64'(0));
        chk("size_pending", 64'(q_sz.size()), 64'(0));
        chk("busy_fall", 64'(bus.busy), 64'(0));
    endtask

    task automatic run_job(input bit sz, input int gap, input bit junk);
        load_job(sz, gap, junk);
        wait_job();
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_size  = 1'b0;
        bus.in_row_a = '0;
        bus.in_row_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Size 16: identity A, single-element B.
        clear_mats();
        for (int i = 0; i < 16; i++) mat_a[i][i] = 4'd1;
        mat_b[3][7] = 4'd9;
        run_job(1'b0, 0, 1'b0);

        // Size 32 fully dense.
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                mat_a[r][c] = 4'hF;
                mat_b[r][c] = 4'h1;
            end
        run_job(1'b1, 0, 1'b0);

        // Size 16 all zero.
        clear_mats();
        run_job(1'b0, 0, 1'b0);

        // Gapped load with traffic during SCAN, then the same matrices gap-free.
        fill_rand(40);
        run_job(1'b0, 3, 1'b1);
        run_job(1'b0, 0, 1'b0);

        // Back-to-back: size 32 then size 16 right after busy falls.
        fill_rand(25);
        run_job(1'b1, 0, 1'b1);
        fill_rand(15);
        run_job(1'b0, 0, 1'b0);

        // Reset during the fifth A triple, then a fresh job.
        clear_mats();
        for (int i = 0; i < 16; i++) mat_a[i][i] = 4'd1;
        mat_b[2][5] = 4'd3;
        load_job(1'b0, 0, 1'b0);
        while (cyc < last_cyc + 256 + 2 + 4) begin
            @(posedge clk); #1;
        end
        chk("abort_5th_triple", 64'({bus.out_valid_a, bus.out_row_a}), 64'({1'b1, 5'd4}));
        rst_n = 1'b0;
        q_sz.delete();
        q_a.delete();
        q_b.delete();
        q_done.delete();
        #1;
        chk("abort_outputs_zero", outs(), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_quiet", outs(), 64'(0));
        fill_rand(30);
        run_job(1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
